// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RISC-V subset decoder with register file, write-back bypass and ID/EX pipeline register.
module decode_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit BYPASS    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            valid_d,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic            valid_e,
    output logic            illegal_e,
    output logic            reg_write_e,
    output logic            alu_src_e,
    output logic            mem_write_e,
    output logic [1:0]      result_src_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic [2:0]      alu_control_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e
);
    localparam bit SMALL = (REG_COUNT == 16);
    localparam int AW    = SMALL ? 4 : 5;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic [1:0]      result_src;
        logic            branch;
        logic            jump;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    function automatic logic in_range(input logic [4:0] r);
        return !(SMALL && r[4]);
    endfunction

    logic [XLEN-1:0] rf [REG_COUNT];
    logic [4:0]      rs1, rs2, rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1, rd2, imm_ext;
    logic [31:0]     imm32;
    imm_src_t        imm_src;
    logic            known, is_alu, is_r, bad_f3, illegal;
    logic            use_rs1, use_rs2, use_rd;
    logic            reg_write, alu_src, mem_write, branch, jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    idex_t           d, q;

    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];
    assign rd     = instr_d[11:7];
    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];

    // Indices beyond REG_COUNT are never written so they cannot alias onto low entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (reg_write_w && rd_w != 5'd0 && in_range(rd_w)) begin
            rf[rd_w[AW-1:0]] <= result_w;
        end
    end

    assign rd1 = (BYPASS && reg_write_w && rd_w == rs1 && rs1 != 5'd0) ? result_w :
                 (rs1 == 5'd0 || !in_range(rs1)) ? '0 : rf[rs1[AW-1:0]];
    assign rd2 = (BYPASS && reg_write_w && rd_w == rs2 && rs2 != 5'd0) ? result_w :
                 (rs2 == 5'd0 || !in_range(rs2)) ? '0 : rf[rs2[AW-1:0]];

    always_comb begin
        known      = 1'b1;
        is_alu     = 1'b0;
        is_r       = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        jump       = 1'b0;
        imm_src    = IMM_NONE;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        case (opcode)
            7'b0000011: begin
                reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 2'b01;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            7'b0100011: begin
                imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0110011: begin
                reg_write = 1'b1; is_alu = 1'b1; is_r = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            7'b0010011: begin
                reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; is_alu = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            7'b1100011: begin
                imm_src = IMM_B; branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1101111: begin
                reg_write = 1'b1; imm_src = IMM_J; jump = 1'b1; result_src = 2'b10;
                use_rd = 1'b1;
            end
            7'b0110111: begin
                reg_write = 1'b1; imm_src = IMM_U; alu_src = 1'b1; result_src = 2'b11;
                use_rd = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = branch ? 3'b001 : 3'b000;
        bad_f3      = 1'b0;
        if (is_alu) begin
            case (funct3)
                3'b000:  alu_control = (is_r && instr_d[30]) ? 3'b001 : 3'b000;
                3'b111:  alu_control = 3'b010;
                3'b110:  alu_control = 3'b011;
                3'b010:  alu_control = 3'b101;
                default: bad_f3 = 1'b1;
            endcase
        end
    end

    assign illegal = !known || bad_f3 || (use_rs1 && !in_range(rs1)) ||
                     (use_rs2 && !in_range(rs2)) || (use_rd && !in_range(rd));

    assign imm32 = (imm_src == IMM_I) ? {{20{instr_d[31]}}, instr_d[31:20]} :
                   (imm_src == IMM_S) ? {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]} :
                   (imm_src == IMM_B) ? {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0} :
                   (imm_src == IMM_J) ? {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0} :
                   (imm_src == IMM_U) ? {instr_d[31:12], 12'h000} : 32'd0;
    assign imm_ext = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    // Illegal instructions still travel down the pipe, but with every side effect removed.
    always_comb begin
        d             = '0;
        d.valid       = 1'b1;
        d.illegal     = illegal;
        d.reg_write   = reg_write && !illegal;
        d.alu_src     = alu_src;
        d.mem_write   = mem_write && !illegal;
        d.result_src  = result_src;
        d.branch      = branch && !illegal;
        d.jump        = jump && !illegal;
        d.alu_control = alu_control;
        d.rd1         = rd1;
        d.rd2         = rd2;
        d.imm_ext     = imm_ext;
        d.pc          = pc_d;
        d.pc_plus4    = pc_plus4_d;
        d.rs1         = rs1;
        d.rs2         = rs2;
        d.rd          = rd;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_e || (!stall_e && !valid_d)) q <= '0;
        else if (!stall_e) q <= d;
    end

    assign valid_e       = q.valid;
    assign illegal_e     = q.illegal;
    assign reg_write_e   = q.reg_write;
    assign alu_src_e     = q.alu_src;
    assign mem_write_e   = q.mem_write;
    assign result_src_e  = q.result_src;
    assign branch_e      = q.branch;
    assign jump_e        = q.jump;
    assign alu_control_e = q.alu_control;
    assign rd1_e         = q.rd1;
    assign rd2_e         = q.rd2;
    assign imm_ext_e     = q.imm_ext;
    assign pc_e          = q.pc;
    assign pc_plus4_e    = q.pc_plus4;
    assign rs1_e         = q.rs1;
    assign rs2_e         = q.rs2;
    assign rd_e          = q.rd;
endmodule
